mips_cpu_muldiv_ctrl: RTL
=========================

// Module: mips_cpu_muldiv_ctrl
// PURPOSE
//  Sequencer for the HI/LO register pair. Runs iterative MULT/MULTU/DIV/DIVU and
//  MTHI/MTLO, then drives the data and write-enables of the HI and LO registers.
//  Tells the pipeline to stall any mul/div/move or MFHI/MFLO while an operation
//  is in flight. Sits between the decode/execute stage and the two HI/LO registers.
// PARAMETERS
//  BITS_PER_CYC  1             quotient/multiplier bits retired per cycle; 1, 2 or 4
//  DIV0_LO       32'hFFFF_FFFF LO value written on divide-by-zero
// PORTS
//  clk      in   1   clock
//  reset    in   1   reset, synchronous, active-high
//  start    in   1   operation request; sampled only in IDLE
//  op       in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved (no-op)
//  rs_val   in   32  multiplicand / dividend / move source
//  rt_val   in   32  multiplier / divisor
//  mf_req   in   1   MFHI/MFLO in execute this cycle
//  hi_data  out  32  data for the HI register
//  hi_we    out  1   HI register enable
//  lo_data  out  32  data for the LO register
//  lo_we    out  1   LO register enable
//  busy     out  1   arithmetic operation in flight
//  stall    out  1   busy & (start | mf_req)
//  done     out  1   one-cycle pulse when the result is written
// BEHAVIOUR
//  Reset: state IDLE; hi_we=lo_we=busy=stall=done=0; hi_data=lo_data=0; iteration count 0.
//  N = 32/BITS_PER_CYC. States: IDLE -> CALC -> SIGN -> WRITE -> IDLE.
//  IDLE, start & op MULT..DIVU, at edge E0:
//   - latch |rs|, |rt| (signed ops) or raw values (unsigned ops)
//   - latch result sign and dividend sign; go to CALC; busy=1 from the next cycle.
//  CALC: N edges, each retiring BITS_PER_CYC bits.
//   - multiply: shift-add into a 64-bit accumulator.
//   - divide: restoring division, producing quotient and remainder.
//  SIGN (1 cycle): negate the results as needed.
//   - MULT: negate the 64-bit product if the operand signs differ.
//   - DIV: negate the quotient if the operand signs differ.
//   - DIV: the remainder takes the dividend's sign.
//  WRITE (1 cycle):
//   - hi_we=lo_we=done=1.
//   - multiply: HI=product[63:32], LO=product[31:0].
//   - divide: LO=quotient, HI=remainder.
//   - Returns to IDLE at the next edge. busy is high throughout CALC, SIGN and WRITE.
//  Latency: enables high in cycle N+2 after E0; registers update at edge N+2 (N=32 -> 34).
//  Divide-by-zero (rt=0): skip CALC.
//   - SIGN is followed by WRITE with LO=DIV0_LO and HI=rs_val (raw); busy for 2 cycles.
//  Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0 (falls out of the magnitude path).
//  MTHI/MTLO in IDLE: combinational, same cycle.
//   - hi_data (or lo_data) = rs_val and the matching we=1; the other we=0.
//   - busy stays 0; done=0; no state change.
//  start while busy: ignored (no state or operand change); stall=1 until IDLE.
//   - The requester holds start; it is accepted in the first IDLE cycle.
//  mf_req while busy: stall=1. mf_req in IDLE: stall=0 (the HI/LO registers are already current).
//  Reserved op codes: ignored in IDLE; no enables.
//  Outside WRITE and moves: hi_data/lo_data hold the last result register value; enables are 0.
//  Reset mid-operation: abort to IDLE next edge; no enable pulse; partial results discarded.
// TESTING
//  1. MULT rs=-3, rt=7 -> one pulse at cycle 34: HI=FFFFFFFF, LO=FFFFFFEB; busy cycles 1-34.
//  2. MULTU FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE, LO=00000001; DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//  3. DIVU 100/0 -> LO=FFFFFFFF, HI=00000064 after 2 busy cycles; DIV 80000000/-1 -> LO=80000000, HI=0.
//  4. MTLO 0x1234 in IDLE -> lo_we=1 and lo_data=0x1234 same cycle; hi_we=0; busy=0.
//  5. start/mf_req held during DIVU -> stall=1 every busy cycle; start accepted the cycle after WRITE.
//  6. reset at cycle 10 of MULT -> IDLE, no enables; BITS_PER_CYC=4 MULT completes at cycle 10.

Source files
------------

// File: rtl/mips_cpu_muldiv_ctrl.sv
// HI/LO sequencer: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO, driving the
// HI and LO register write ports and stalling the pipeline while busy.
//
// Handshake: start is a level request that is sampled only in IDLE. The
// requester holds start (and its operands) until the first IDLE cycle; while an
// operation is in flight, stall = busy & (start | mf_req), and start is ignored.
module mips_cpu_muldiv_ctrl #(
    parameter int          BITS_PER_CYC = 1,
    parameter logic [31:0] DIV0_LO      = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_req,
    output logic [31:0] hi_data,
    output logic        hi_we,
    output logic [31:0] lo_data,
    output logic        lo_we,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    localparam int         N    = 32 / BITS_PER_CYC;
    localparam logic [5:0] LAST = 6'(N - 1);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_WRITE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Shared iteration registers: multiply keeps the 64-bit accumulator in
    // {acc_hi, acc_lo}; divide keeps remainder in acc_hi and quotient in acc_lo.
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] operand;
    logic [5:0]  cnt;
    logic        is_div;
    logic        div0;
    logic        res_neg;
    logic        rem_neg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        signed_op;
    logic        accept;
    logic        mv_hi;
    logic        mv_lo;
    logic        wr;
    logic [31:0] rs_abs;
    logic [31:0] rt_abs;
    logic [63:0] prod_neg;

    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [32:0] trial;
    logic [32:0] sum;

    // MULT (0) and DIV (2) are the signed operations; op[2]=0 means arithmetic.
    assign signed_op = ~op[0];
    assign accept    = (state == S_IDLE) & start & ~op[2] & ~reset;
    assign mv_hi     = (state == S_IDLE) & start & (op == OP_MTHI) & ~reset;
    assign mv_lo     = (state == S_IDLE) & start & (op == OP_MTLO) & ~reset;
    assign wr        = (state == S_WRITE) & ~reset;
    assign rs_abs    = (signed_op & rs_val[31]) ? -rs_val : rs_val;
    assign rt_abs    = (signed_op & rt_val[31]) ? -rt_val : rt_val;
    assign prod_neg  = -{acc_hi, acc_lo};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; a zero divisor skips the iteration entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (op[1] && rt_val == 32'd0) ? S_SIGN : S_CALC;
            S_CALC:  if (cnt == LAST) state_nxt = S_SIGN;
            S_SIGN:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One iteration: BITS_PER_CYC radix-2 shift-add or restoring-divide steps.
    always_comb begin
        step_hi = acc_hi;
        step_lo = acc_lo;
        trial   = 33'd0;
        sum     = 33'd0;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            if (is_div) begin
                trial = {step_hi, step_lo[31]};
                if (trial >= {1'b0, operand}) begin
                    // True difference is below the divisor, so 32 bits suffice.
                    step_hi = trial[31:0] - operand;
                    step_lo = {step_lo[30:0], 1'b1};
                end else begin
                    step_hi = trial[31:0];
                    step_lo = {step_lo[30:0], 1'b0};
                end
            end else begin
                sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, operand} : 33'd0);
                step_lo = {sum[0], step_lo[31:1]};
                step_hi = sum[32:1];
            end
        end
    end

    // Operand capture, iteration, sign fix-up and the held HI/LO copies.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            div0    <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            hi_reg  <= '0;
            lo_reg  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        is_div  <= op[1];
                        res_neg <= signed_op & (rs_val[31] ^ rt_val[31]);
                        rem_neg <= signed_op & rs_val[31];
                        if (op[1]) begin
                            div0    <= (rt_val == 32'd0);
                            operand <= rt_abs;
                            if (rt_val == 32'd0) begin
                                // Divide-by-zero result is loaded directly.
                                acc_hi <= rs_val;
                                acc_lo <= DIV0_LO;
                            end else begin
                                acc_hi <= '0;
                                acc_lo <= rs_abs;
                            end
                        end else begin
                            div0    <= 1'b0;
                            operand <= rs_abs;
                            acc_hi  <= '0;
                            acc_lo  <= rt_abs;
                        end
                    end
                    if (mv_hi) hi_reg <= rs_val;
                    if (mv_lo) lo_reg <= rs_val;
                end
                S_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 6'd1;
                end
                S_SIGN: begin
                    if (!div0) begin
                        if (is_div) begin
                            if (res_neg) acc_lo <= -acc_lo;
                            if (rem_neg) acc_hi <= -acc_hi;
                        end else if (res_neg) begin
                            acc_hi <= prod_neg[63:32];
                            acc_lo <= prod_neg[31:0];
                        end
                    end
                end
                S_WRITE: begin
                    hi_reg <= acc_hi;
                    lo_reg <= acc_lo;
                end
                default: ;
            endcase
        end
    end

    // Register-port drive: results in WRITE, moves in IDLE, otherwise hold.
    always_comb begin
        hi_we   = wr | mv_hi;
        lo_we   = wr | mv_lo;
        hi_data = hi_reg;
        lo_data = lo_reg;
        if (wr) begin
            hi_data = acc_hi;
            lo_data = acc_lo;
        end else begin
            if (mv_hi) hi_data = rs_val;
            if (mv_lo) lo_data = rs_val;
        end
        busy  = (state != S_IDLE);
        stall = busy & (start | mf_req);
        done  = wr;
    end

endmodule
